// File: rtl/dm_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dm_arbiter_pkg
//   Shared encodings for the data-memory arbiter: grant codes driven on the
//   grant port, FSM state codes, and the word-alignment helper used on both
//   address paths.
// ----------------------------------------------------------------------------
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_CPU  = 2'b01,
        GRANT_DMA  = 2'b10
    } grant_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_e;

    // The DM is word-addressed on its low bits; byte offsets never reach it.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dm_port_mux.sv
// ----------------------------------------------------------------------------
// dm_port_mux
//   Purely combinational payload mux onto the single data-memory port.
//   Ports:
//     grant                      - current grant code (none / CPU / DMA)
//     cpu_pc/addr/wdata, cpu_we  - MEM-stage request payload
//     dma_addr/wdata, dma_we     - DMA request payload
//     DM_PC/Addr/WData, DM_WE    - payload presented to the data memory
// ----------------------------------------------------------------------------
module dm_port_mux
    import dm_arbiter_pkg::*;
(
    input  logic [1:0]  grant,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_we,
    output logic [31:0] DM_PC,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WData,
    output logic [3:0]  DM_WE
);

    always_comb begin
        DM_PC    = 32'h0;
        DM_Addr  = 32'h0;
        DM_WData = 32'h0;
        DM_WE    = 4'h0;
        case (grant)
            GRANT_CPU: begin
                DM_PC    = cpu_pc;
                DM_Addr  = word_align(cpu_addr);
                DM_WData = cpu_wdata;
                DM_WE    = cpu_we;
            end
            GRANT_DMA: begin
                // DM_PC stays zero so DMA writes are never tied to a CPU PC.
                DM_Addr  = word_align(dma_addr);
                DM_WData = dma_wdata;
                DM_WE    = dma_we;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
//   Arbitrates the single data-memory port between the CPU MEM stage and a
//   DMA engine. Grants are combinational, so a granted access completes in
//   its grant cycle. The CPU normally wins; DMA is forced through after
//   STARVE_MAX denied cycles, and locked DMA bursts are capped at BURST_MAX
//   beats when the CPU is waiting.
//   Ports:
//     clk, reset                  - clock, async active-low reset
//     cpu_req/pc/addr/wdata/we    - MEM-stage request
//     cpu_stall, cpu_rdata        - pipeline freeze, read data to MEM
//     dma_req/lock/addr/wdata/we  - DMA request, lock keeps the grant
//     dma_ack, dma_rdata          - DMA access completes, read data to DMA
//     DM_PC/Addr/WData/WE, DM_RData - data-memory port
//     grant                       - 00 none, 01 CPU, 10 DMA
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | no DMA lock held; CPU priority with starvation escape
//   S_BURST | DMA owns a locked burst; burst_cnt counts beats
// ----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_we,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] DM_PC,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WData,
    output logic [3:0]  DM_WE,
    input  logic [31:0] DM_RData,
    output logic [1:0]  grant
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

    arb_state_e    state, state_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [BW-1:0] burst_cnt, burst_nx;
    grant_e        grant_sel;
    grant_e        grant_eff;
    logic          dma_idle_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            burst_cnt  <= burst_nx;
        end
    end

    always_comb begin
        grant_sel    = GRANT_NONE;
        state_nx     = state;
        starve_nx    = starve_cnt;
        burst_nx     = burst_cnt;
        dma_idle_win = dma_req && ((starve_cnt == STARVE_LIM) || !cpu_req);

        case (state)
            S_IDLE: begin
                burst_nx = '0;
                if (dma_idle_win) begin
                    grant_sel = GRANT_DMA;
                    if (dma_lock) begin
                        state_nx = S_BURST;
                        burst_nx = BW'(1);
                    end
                end else if (cpu_req) begin
                    grant_sel = GRANT_CPU;
                end
            end
            S_BURST: begin
                if (dma_req && dma_lock && ((burst_cnt < BURST_LIM) || !cpu_req)) begin
                    grant_sel = GRANT_DMA;
                    if (burst_cnt != BURST_LIM)
                        burst_nx = burst_cnt + 1'b1;
                end else begin
                    state_nx = S_IDLE;
                    burst_nx = '0;
                    // Lock still held means the burst cap ended it with the
                    // CPU waiting: hand over in this same cycle, no idle gap.
                    // Otherwise the burst simply ended; arbitrate as idle.
                    if (dma_req && dma_lock)
                        grant_sel = GRANT_CPU;
                    else if (dma_idle_win)
                        grant_sel = GRANT_DMA;
                    else if (cpu_req)
                        grant_sel = GRANT_CPU;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (!dma_req || (grant_sel == GRANT_DMA))
            starve_nx = '0;
        else if ((grant_sel == GRANT_CPU) && (starve_cnt != STARVE_LIM))
            starve_nx = starve_cnt + 1'b1;
    end

    // Reset must silence the port immediately, not at the next edge.
    assign grant_eff = reset ? grant_sel : GRANT_NONE;
    assign grant     = grant_eff;
    assign cpu_stall = cpu_req && (grant_eff != GRANT_CPU);
    assign dma_ack   = (grant_eff == GRANT_DMA);
    assign cpu_rdata = DM_RData;
    assign dma_rdata = DM_RData;

    dm_port_mux u_port_mux (
        .grant     (grant),
        .cpu_pc    (cpu_pc),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .DM_PC     (DM_PC),
        .DM_Addr   (DM_Addr),
        .DM_WData  (DM_WData),
        .DM_WE     (DM_WE)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_pc, cpu_addr, cpu_wdata;
    logic [3:0]  cpu_we;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_lock;
    logic [31:0] dma_addr, dma_wdata;
    logic [3:0]  dma_we;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic [31:0] DM_PC, DM_Addr, DM_WData;
    logic [3:0]  DM_WE;
    logic [31:0] DM_RData;
    logic [1:0]  grant;

    int vectors    = 0;
    int miscompares = 0;
    int ack_count;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_pc    (cpu_pc),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .DM_PC     (DM_PC),
        .DM_Addr   (DM_Addr),
        .DM_WData  (DM_WData),
        .DM_WE     (DM_WE),
        .DM_RData  (DM_RData),
        .grant     (grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_pc    = 32'h0000_0400;
        cpu_addr  = 32'h0000_1007;
        cpu_wdata = 32'h1234_5678;
        cpu_we    = 4'hF;
        dma_req   = 1'b0;
        dma_lock  = 1'b0;
        dma_addr  = 32'h0000_2003;
        dma_wdata = 32'hDEAD_BEEF;
        dma_we    = 4'h3;
        DM_RData  = 32'hCAFE_0001;
        #1;

        // Reset state, with and without a pending CPU request
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_dm_we", 32'(DM_WE), 32'h0);
        check("rst_dma_ack", 32'(dma_ack), 32'h0);
        check("rst_stall_idle", 32'(cpu_stall), 32'h0);
        cpu_req = 1'b1;
        #1;
        check("rst_stall_req", 32'(cpu_stall), 32'h1);
        check("rst_grant_req", 32'(grant), 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // No requests
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_dm_we", 32'(DM_WE), 32'h0);
        check("idle_dm_pc", DM_PC, 32'h0);
        check("idle_dm_addr", DM_Addr, 32'h0);
        check("idle_stall", 32'(cpu_stall), 32'h0);
        check("idle_ack", 32'(dma_ack), 32'h0);

        // Single CPU access, byte offset stripped, same-cycle completion
        cpu_req = 1'b1;
        #1;
        check("cpu_grant", 32'(grant), 32'h1);
        check("cpu_dm_addr", DM_Addr, 32'h0000_1004);
        check("cpu_stall", 32'(cpu_stall), 32'h0);
        check("cpu_dm_we", 32'(DM_WE), 32'hF);
        check("cpu_dm_pc", DM_PC, 32'h0000_0400);
        check("cpu_dm_wdata", DM_WData, 32'h1234_5678);
        check("cpu_rdata", cpu_rdata, 32'hCAFE_0001);
        tick();

        // Contention without lock: CPU x4, DMA on the 5th, then CPU
        dma_req = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("starve_grant", 32'(grant), (i == 4) ? 32'h2 : 32'h1);
            if (i == 4) begin
                check("starve_ack", 32'(dma_ack), 32'h1);
                check("starve_stall", 32'(cpu_stall), 32'h1);
                check("dma_dm_addr", DM_Addr, 32'h0000_2000);
                check("dma_dm_pc", DM_PC, 32'h0);
                check("dma_dm_we", 32'(DM_WE), 32'h3);
                check("dma_dm_wdata", DM_WData, 32'hDEAD_BEEF);
                check("dma_rdata", dma_rdata, 32'hCAFE_0001);
            end
            tick();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();

        // Locked burst against a waiting CPU: 4 CPU, 8 DMA, then CPU at once
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        ack_count = 0;
        #1;
        for (int i = 0; i < 14; i++) begin
            check("burst_cap_grant", 32'(grant), (i >= 4 && i < 12) ? 32'h2 : 32'h1);
            if (dma_ack) ack_count++;
            tick();
        end
        check("burst_cap_acks", 32'(ack_count), 32'd8);
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        tick();

        // Locked burst with no CPU: grant retained past the cap
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("burst_free_ack", 32'(dma_ack), 32'h1);
            tick();
        end
        check("burst_cnt_sat", 32'(dut.burst_cnt), 32'd8);
        check("burst_state", 32'(dut.state), 32'h1);
        cpu_req = 1'b1;
        #1;
        check("burst_handover", 32'(grant), 32'h1);
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        dma_lock = 1'b0;
        tick();
        tick();

        // Reset in the 3rd beat of a burst
        dma_req  = 1'b1;
        dma_lock = 1'b1;
        tick();
        tick();
        check("beat3_grant", 32'(grant), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_dm_we", 32'(DM_WE), 32'h0);
        check("mid_rst_ack", 32'(dma_ack), 32'h0);
        check("mid_rst_state", 32'(dut.state), 32'h0);
        cpu_req = 1'b1;
        #1;
        check("mid_rst_stall", 32'(cpu_stall), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("post_rst_grant", 32'(grant), 32'h1);
        check("post_rst_stall", 32'(cpu_stall), 32'h0);
        tick();
        check("post_rst_grant2", 32'(grant), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
